// File: rtl/ahb_sram_pkg.sv
// Shared encodings, FSM states and lane helpers for the parametrised AHB-Lite SRAM controller.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_RDATA  = 3'd2,
    ST_RSTALL = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  // Number of byte-address bits that select a lane within one bus word.
  function automatic int unsigned lane_shift(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ahb_sram_ctrl_param_if.sv
// AHB-Lite signal bundle between a master and the SRAM controller slave.
interface ahb_sram_ctrl_param_if #(
  parameter int unsigned DATA_W = 32
);

  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready_in;
  logic              hreadyout;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
    output hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_sram_ben_gen.sv
// Little-endian byte-lane mask for a transfer; an all-zero mask flags an oversize or misaligned transfer.
module ahb_sram_ben_gen #(
  parameter  int unsigned NB    = 4,
  localparam int unsigned LSB_W = $clog2(NB)
) (
  input  logic [2:0]       hsize_i,
  input  logic [LSB_W-1:0] addr_i,
  output logic [NB-1:0]    lanes_o
);

  logic [31:0] low_mask;
  logic [31:0] addr_ext;
  logic        aligned;

  assign low_mask = (32'd1 << hsize_i) - 32'd1;
  assign addr_ext = 32'(addr_i);
  assign aligned  = ((addr_ext & low_mask) == 32'd0) && (32'(hsize_i) <= LSB_W);

  // A lane is selected when it falls in the same size-aligned block as the address.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign lanes_o[b] = aligned && ((32'(b) & ~low_mask) == (addr_ext & ~low_mask));
  end

endmodule

// File: rtl/ahb_sram_ctrl_param.sv
// AHB-Lite slave in front of a single-port synchronous SRAM: pipelined zero-wait reads/writes,
// one wait state on a read that collides with a pending write, two-cycle ERROR on illegal transfers.
module ahb_sram_ctrl_param
  import ahb_sram_pkg::*;
#(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned SRAM_AW = 12,
  localparam int unsigned NB      = DATA_W / 8
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  ahb_sram_ctrl_param_if.slave   ahb,
  output logic                   sram_csn,
  output logic                   sram_wen,
  output logic [NB-1:0]          sram_ben,
  output logic [SRAM_AW-1:0]     sram_a,
  output logic [DATA_W-1:0]      sram_d,
  input  logic [DATA_W-1:0]      sram_q
);

  localparam int unsigned LSB_W = lane_shift(DATA_W);
  localparam int unsigned AHI   = SRAM_AW + LSB_W;

  state_e              state_q, state_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [NB-1:0]       lanes_q, lanes_d;
  logic                hreadyout_q, hreadyout_d;
  logic [1:0]          hresp_q, hresp_d;

  logic [NB-1:0]       lanes_c;
  logic [SRAM_AW-1:0]  word_addr_c;
  logic                valid_c, legal_c, wr_c, rd_c, illegal_c;
  logic                unused_c;

  // Upper address bits alias; burst type and the BUSY/SEQ distinction carry no meaning here.
  assign unused_c = ^{ahb.haddr[31:AHI], ahb.htrans[0], ahb.hburst};

  assign word_addr_c = ahb.haddr[AHI-1:LSB_W];

  ahb_sram_ben_gen #(.NB(NB)) u_ben_gen (
    .hsize_i (ahb.hsize),
    .addr_i  (ahb.haddr[LSB_W-1:0]),
    .lanes_o (lanes_c)
  );

  assign valid_c   = hresetn & ahb.hsel & ahb.hready_in & ahb.htrans[1];
  assign legal_c   = |lanes_c;
  assign wr_c      = valid_c & legal_c & ahb.hwrite;
  assign rd_c      = valid_c & legal_c & ~ahb.hwrite;
  assign illegal_c = valid_c & ~legal_c;

  // Next state, captured address/lanes and the response registered for the coming data phase.
  always_comb begin
    state_d = ST_IDLE;
    addr_d  = addr_q;
    lanes_d = lanes_q;
    case (state_q)
      ST_RSTALL: state_d = ST_RDATA;
      ST_ERR1:   state_d = ST_ERR2;
      default: begin
        if (illegal_c) begin
          state_d = ST_ERR1;
        end else if (wr_c) begin
          state_d = ST_WDATA;
          addr_d  = word_addr_c;
          lanes_d = lanes_c;
        end else if (rd_c) begin
          if (state_q == ST_WDATA) begin
            state_d = ST_RSTALL;
            addr_d  = word_addr_c;
          end else begin
            state_d = ST_RDATA;
          end
        end
      end
    endcase
    hreadyout_d = !((state_d == ST_RSTALL) || (state_d == ST_ERR1));
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      lanes_q     <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lanes_q     <= lanes_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // SRAM port: the pending write owns it in WDATA; otherwise reads go straight from haddr.
  always_comb begin
    sram_csn = 1'b1;
    sram_wen = 1'b1;
    sram_ben = '0;
    sram_a   = word_addr_c;
    sram_d   = '0;
    case (state_q)
      ST_WDATA: begin
        sram_csn = 1'b0;
        sram_wen = 1'b0;
        sram_ben = lanes_q;
        sram_a   = addr_q;
        sram_d   = ahb.hwdata;
      end
      ST_RSTALL: begin
        sram_csn = 1'b0;
        sram_a   = addr_q;
      end
      default: begin
        if (rd_c) sram_csn = 1'b0;
      end
    endcase
  end

  assign ahb.hreadyout = hreadyout_q;
  assign ahb.hresp     = hresp_q;
  assign ahb.hrdata    = (state_q == ST_RDATA) ? sram_q : '0;

endmodule

// File: tb/tb_ahb_sram_ctrl_param.sv
// Directed bench for ahb_sram_ctrl_param (32-bit, 4K words) with a behavioural SRAM.
module tb_ahb_sram_ctrl_param;
  import ahb_sram_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRAM_AW = 12;
  localparam int unsigned NB      = 4;

  logic                hclk = 1'b0;
  logic                hresetn;
  logic                sram_csn, sram_wen;
  logic [NB-1:0]       sram_ben;
  logic [SRAM_AW-1:0]  sram_a;
  logic [DATA_W-1:0]   sram_d, sram_q;
  logic [DATA_W-1:0]   mem [0:(1<<SRAM_AW)-1];

  int n_checks = 0;
  int n_errors = 0;
  int stalls;

  ahb_sram_ctrl_param_if #(.DATA_W(DATA_W)) ahb ();
  assign ahb.hready_in = ahb.hreadyout;

  ahb_sram_ctrl_param #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .ahb      (ahb),
    .sram_csn (sram_csn),
    .sram_wen (sram_wen),
    .sram_ben (sram_ben),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_q   (sram_q)
  );

  always #5 hclk = ~hclk;

  // Synchronous single-port SRAM with per-lane writes and registered read data.
  always @(posedge hclk) begin
    if (!sram_csn) begin
      if (!sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_ben[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    ahb.hsel   = 1'b0;
    ahb.htrans = HTRANS_IDLE;
    ahb.hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [1:0] tr);
    ahb.hsel   = 1'b1;
    ahb.haddr  = a;
    ahb.hwrite = wr;
    ahb.hsize  = sz;
    ahb.htrans = tr;
  endtask

  task automatic write_beat(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                            input logic [3:0] exp_ben, input string tag);
    addr_phase(1'b1, a, sz, HTRANS_NONSEQ);
    #1;
    chk({tag, ".addr_csn"}, 64'(sram_csn), 64'd1);
    tick();
    bus_idle();
    ahb.hwdata = d;
    #1;
    chk({tag, ".csn"}, 64'(sram_csn), 64'd0);
    chk({tag, ".wen"}, 64'(sram_wen), 64'd0);
    chk({tag, ".a"},   64'(sram_a), 64'(a[13:2]));
    chk({tag, ".ben"}, 64'(sram_ben), 64'(exp_ben));
    chk({tag, ".d"},   64'(sram_d), 64'(d));
    chk({tag, ".rdata0"}, 64'(ahb.hrdata), 64'd0);
    tick();
  endtask

  task automatic read_beat(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr_phase(1'b0, a, HSIZE_WORD, HTRANS_NONSEQ);
    #1;
    chk({tag, ".csn"},   64'(sram_csn), 64'd0);
    chk({tag, ".wen"},   64'(sram_wen), 64'd1);
    chk({tag, ".a"},     64'(sram_a), 64'(a[13:2]));
    chk({tag, ".ready"}, 64'(ahb.hreadyout), 64'd1);
    tick();
    bus_idle();
    #1;
    chk({tag, ".rdata"}, 64'(ahb.hrdata), 64'(exp));
    chk({tag, ".rdy"},   64'(ahb.hreadyout), 64'd1);
    chk({tag, ".resp"},  64'(ahb.hresp), 64'(HRESP_OKAY));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hresetn    = 1'b0;
    bus_idle();
    ahb.haddr  = '0;
    ahb.hsize  = HSIZE_WORD;
    ahb.hburst = 3'b000;
    ahb.hwdata = '0;
    #12;
    chk("rst.hreadyout", 64'(ahb.hreadyout), 64'd1);
    chk("rst.hresp",     64'(ahb.hresp), 64'd0);
    chk("rst.hrdata",    64'(ahb.hrdata), 64'd0);
    chk("rst.csn",       64'(sram_csn), 64'd1);
    chk("rst.wen",       64'(sram_wen), 64'd1);
    chk("rst.ben",       64'(sram_ben), 64'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    tick();

    // 1: word write then a separate read, zero wait.
    write_beat(32'h10, HSIZE_WORD, 32'hDEADBEEF, 4'b1111, "t1_wr");
    read_beat(32'h10, 32'hDEADBEEF, "t1_rd");

    // 2: byte lane 3 over a pre-filled word.
    write_beat(32'h10, HSIZE_WORD, 32'h11223344, 4'b1111, "t2_fill");
    write_beat(32'h13, HSIZE_BYTE, 32'hAA000000, 4'b1000, "t2_byte");
    read_beat(32'h10, 32'hAA223344, "t2_rd");

    // BUSY with hsel high is not a transfer.
    addr_phase(1'b0, 32'h10, HSIZE_WORD, HTRANS_BUSY);
    #1;
    chk("busy.csn", 64'(sram_csn), 64'd1);
    tick();
    bus_idle();
    #1;
    chk("busy.rdata", 64'(ahb.hrdata), 64'd0);
    chk("busy.resp",  64'(ahb.hresp), 64'd0);
    tick();

    // 3: read directly after write to the same word costs one wait state.
    addr_phase(1'b1, 32'h20, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    ahb.hwdata = 32'h5;
    addr_phase(1'b0, 32'h20, HSIZE_WORD, HTRANS_NONSEQ);
    #1;
    chk("t3.wdata_wen",   64'(sram_wen), 64'd0);
    chk("t3.wdata_ready", 64'(ahb.hreadyout), 64'd1);
    tick();
    bus_idle();
    #1;
    chk("t3.stall_ready", 64'(ahb.hreadyout), 64'd0);
    chk("t3.stall_resp",  64'(ahb.hresp), 64'd0);
    chk("t3.stall_csn",   64'(sram_csn), 64'd0);
    chk("t3.stall_wen",   64'(sram_wen), 64'd1);
    chk("t3.stall_a",     64'(sram_a), 64'h8);
    stalls = 0;
    while (ahb.hreadyout !== 1'b1 && stalls < 8) begin
      stalls++;
      tick();
    end
    chk("t3.wait_states", 64'(stalls), 64'd1);
    chk("t3.rdata",       64'(ahb.hrdata), 64'h5);
    tick();

    // 4: INCR4 write, then WRAP4 read from 0x108.
    ahb.hburst = 3'b011;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) addr_phase(1'b1, 32'h100 + 32'(4*i), HSIZE_WORD,
                            (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      else bus_idle();
      if (i > 0) ahb.hwdata = 32'(i);
      #1;
      if (i > 0) begin
        chk("t4.wr_wen",   64'(sram_wen), 64'd0);
        chk("t4.wr_a",     64'(sram_a), 64'(32'h40 + 32'(i - 1)));
        chk("t4.wr_d",     64'(sram_d), 64'(i));
        chk("t4.wr_ready", 64'(ahb.hreadyout), 64'd1);
      end
      tick();
    end
    ahb.hburst = 3'b010;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) addr_phase(1'b0, 32'h100 + ((32'd8 + 32'(4*i)) & 32'hF), HSIZE_WORD,
                            (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      else bus_idle();
      #1;
      chk("t4.rd_ready", 64'(ahb.hreadyout), 64'd1);
      if (i > 0) chk("t4.rd_data", 64'(ahb.hrdata), 64'(((i + 1) % 4) + 1));
      tick();
    end
    ahb.hburst = 3'b000;

    // 5a: 64-bit size on a 32-bit bus.
    addr_phase(1'b0, 32'h0, HSIZE_DWORD, HTRANS_NONSEQ);
    #1;
    chk("t5a.addr_csn", 64'(sram_csn), 64'd1);
    tick();
    bus_idle();
    #1;
    chk("t5a.err1_ready", 64'(ahb.hreadyout), 64'd0);
    chk("t5a.err1_resp",  64'(ahb.hresp), 64'd1);
    chk("t5a.err1_csn",   64'(sram_csn), 64'd1);
    tick();
    chk("t5a.err2_ready", 64'(ahb.hreadyout), 64'd1);
    chk("t5a.err2_resp",  64'(ahb.hresp), 64'd1);
    tick();
    chk("t5a.after_resp", 64'(ahb.hresp), 64'd0);

    // 5b: misaligned halfword write, with a legal read issued during ERR2.
    addr_phase(1'b1, 32'h1, HSIZE_HALF, HTRANS_NONSEQ);
    #1;
    chk("t5b.addr_csn", 64'(sram_csn), 64'd1);
    tick();
    bus_idle();
    ahb.hwdata = 32'hFFFFFFFF;
    #1;
    chk("t5b.err1_ready", 64'(ahb.hreadyout), 64'd0);
    chk("t5b.err1_resp",  64'(ahb.hresp), 64'd1);
    chk("t5b.err1_csn",   64'(sram_csn), 64'd1);
    tick();
    addr_phase(1'b0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ);
    #1;
    chk("t5b.err2_ready", 64'(ahb.hreadyout), 64'd1);
    chk("t5b.err2_resp",  64'(ahb.hresp), 64'd1);
    chk("t5b.err2_csn",   64'(sram_csn), 64'd0);
    tick();
    bus_idle();
    #1;
    chk("t5b.rdata", 64'(ahb.hrdata), 64'hAA223344);
    chk("t5b.resp",  64'(ahb.hresp), 64'd0);
    tick();

    // Halfword write to the upper lanes.
    write_beat(32'h12, HSIZE_HALF, 32'hBEEF0000, 4'b1100, "hw_wr");
    read_beat(32'h10, 32'hBEEF3344, "hw_rd");

    // 6: reset asserted in the middle of a WDATA cycle.
    write_beat(32'h30, HSIZE_WORD, 32'h12345678, 4'b1111, "t6_fill");
    addr_phase(1'b1, 32'h30, HSIZE_WORD, HTRANS_NONSEQ);
    tick();
    bus_idle();
    ahb.hwdata = 32'hFFFFFFFF;
    #1;
    chk("t6.pre_csn", 64'(sram_csn), 64'd0);
    #1;
    hresetn = 1'b0;
    #1;
    chk("t6.csn",       64'(sram_csn), 64'd1);
    chk("t6.wen",       64'(sram_wen), 64'd1);
    chk("t6.ben",       64'(sram_ben), 64'd0);
    chk("t6.hreadyout", 64'(ahb.hreadyout), 64'd1);
    chk("t6.hresp",     64'(ahb.hresp), 64'd0);
    @(posedge hclk);
    #2;
    hresetn = 1'b1;
    tick();
    read_beat(32'h30, 32'h12345678, "t6_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_ctrl_param.md
Name: ahb_sram_ctrl_param

Overview:
Parametrised AHB-Lite slave fronting a single-port synchronous SRAM. It has a true address/data pipeline, with zero-wait reads and writes in the common case. It supports byte, halfword and word writes through per-lane byte enables. It inserts a single wait state on a read directly after a write, and returns a two-cycle ERROR for illegal transfers. It replaces the fixed 32-bit controller in the AHB_SRAM subsystem; bursts are handled beat-by-beat from master-supplied addresses.

Parameters:
DATA_W, 32, bus/SRAM data width; legal values 32 or 64.
SRAM_AW, 12, SRAM word-address width (depth = 2^SRAM_AW words).
NB, DATA_W/8, byte lanes (derived, not overridable).

Ports:
hclk  in  1  system clock
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  32  byte address
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  in  1  1 = write
hsize  in  3  transfer size
hburst  in  3  burst type (informational only, ignored)
hwdata  in  DATA_W  write data (data phase)
hready_in  in  1  bus-level HREADY
hreadyout  out  1  slave ready
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  DATA_W  read data
sram_csn  out  1  chip select, active low
sram_wen  out  1  write enable, active low (0 = write, 1 = read)
sram_ben  out  NB  byte-lane write enables, active high
sram_a  out  SRAM_AW  word address
sram_d  out  DATA_W  write data
sram_q  in  DATA_W  read data, valid one cycle after a read access

Behaviour:
- Reset values:
  - state = IDLE; hreadyout = 1; hresp = 00; hrdata = 0.
  - sram_csn = 1, sram_wen = 1, sram_ben = 0.
  - All address/control registers are cleared to 0.
- Valid transfer: hsel & hready_in & htrans[1] at a rising edge. IDLE/BUSY, or hsel = 0, gives OKAY with zero wait and no SRAM access.
- Word address = haddr[SRAM_AW+log2(NB)-1 : log2(NB)]. Upper address bits are ignored, so the SRAM aliases across the address range.
- Illegal transfer, which gives ERROR and no SRAM access:
  - hsize > log2(NB);
  - haddr not aligned to hsize.
- States: IDLE, WDATA, RDATA, RSTALL, ERR1, ERR2.
- Read (state != WDATA at the address phase):
  - SRAM is driven combinationally from haddr in the address-phase cycle: csn = 0, wen = 1.
  - Next cycle is RDATA: hrdata = sram_q, hreadyout = 1. Zero wait.
- Write:
  - Address, size and lanes are registered in the address phase.
  - In the WDATA cycle: csn = 0, wen = 0, sram_a = the registered address, sram_d = hwdata, and sram_ben = lanes from hsize/haddr low bits (little-endian). hreadyout = 1.
- Read accepted while in WDATA (port conflict):
  - Read address and size are registered; next state is RSTALL.
  - RSTALL: read issued from the registered address, hreadyout = 0, hresp = 00.
  - Next cycle is RDATA, hreadyout = 1. Exactly one wait state.
  - Read-after-write to the same address returns the newly written data.
- Error:
  - ERR1: hreadyout = 0, hresp = 01.
  - ERR2: hreadyout = 1, hresp = 01.
  - A valid transfer sampled at the end of ERR2 is processed normally.
- hrdata is 0 outside RDATA.
- sram_ben = 0 whenever sram_wen = 1.
- Back-to-back writes and back-to-back reads sustain one beat per cycle.
- Bursts (INCR, WRAP4/8/16, INCR-undefined) need no special handling, because the master supplies every beat's address. Wrap behaviour is therefore exact.
- Reset mid-transfer: everything returns to reset values immediately. Any in-flight write is aborted, with no SRAM write after the reset edge.

Decomposition:
- Package ahb_sram_pkg holds:
  - htrans, hsize and hresp encodings;
  - the state enum;
  - an NB/lane-shift helper function.
- One combinational sub-module, ahb_sram_ben_gen (inputs: hsize, addr low bits; output: NB-bit lane mask), reused for write lanes and the alignment check.

Test Plan (DATA_W = 32, SRAM_AW = 12):
1. Word write 0x0000_0010 = 0xDEADBEEF, then a NONSEQ read of the same address → read has zero wait states and hrdata = 0xDEADBEEF; SRAM sees csn = 0 / wen = 0 on word 4 with ben = 1111.
2. Byte write 0xAA to 0x13 over a word pre-filled with 0x11223344 → ben = 1000; a read of 0x10 returns 0xAA223344.
3. Write 0x20 = 0x5 directly followed by a read of 0x20 → hreadyout low for exactly 1 cycle (RSTALL), then hrdata = 0x5.
4. INCR4 write of 1, 2, 3, 4 from 0x100, then a WRAP4 read starting at 0x108 → data 3, 4, 1, 2 with zero waits.
5. hsize = 3 (64-bit) on a 32-bit build, then a halfword at 0x1 → each gives hresp = 01 for 2 cycles (hreadyout 0 then 1) and no SRAM access.
6. hresetn asserted during WDATA → csn = 1 in the same cycle, hreadyout = 1, hresp = 00; the target word is unchanged.
